// File: rtl/mem_io_responder.sv
// CPU memory-port responder: RAM window at 0x00..RAM_DEPTH-1 plus RX FIFO, TX holding register, GPIO and timer at 0xF0..0xF5.
// Optional feature macro: MEMIO_TIMER_EN enables the free-running timer at 0xF5 (otherwise 0xF5 reads 0x00).
module mem_io_responder #(
  parameter int RAM_DEPTH  = 224,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  input  logic       rden,
  input  logic       wren,
  output logic [7:0] data_out,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] gpio_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [8:0] RAM_LIM = 9'(RAM_DEPTH);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  logic [7:0]    r_ram [RAM_DEPTH];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_data_out, r_tx_data, r_gpio;
  logic          r_tx_valid, r_overrun;

  logic       w_ram_hit, w_rd, w_full, w_empty, w_push, w_pop;
  logic       w_tx_wr, w_tx_accept, w_tx_xfer;
  logic [7:0] w_rd_data, w_timer_val;

  // A write strobe always wins over a simultaneous read strobe.
  assign w_rd      = rden && !wren;
  assign w_ram_hit = {1'b0, addr} < RAM_LIM;
  assign w_full    = (r_count == FIFO_FULL);
  assign w_empty   = (r_count == '0);
  assign w_push    = rx_valid && !w_full;
  assign w_pop     = w_rd && (addr == 8'hF0) && !w_empty;
  assign w_tx_wr   = wren && (addr == 8'hF2);
  assign w_tx_xfer = r_tx_valid && tx_ready;
  // The holding register is free either when empty or when the host takes it this edge.
  assign w_tx_accept = !r_tx_valid || tx_ready;

  assign data_out = r_data_out;
  assign rx_ready = !w_full;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign gpio_out = r_gpio;

`ifdef MEMIO_TIMER_EN
  logic [7:0] r_timer;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= 8'h00;
    end else if (wren && (addr == 8'hF5)) begin
      r_timer <= 8'h00;
    end else begin
      r_timer <= r_timer + 8'd1;
    end
  end
  assign w_timer_val = r_timer;
`else
  assign w_timer_val = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (wren && w_ram_hit) begin
      r_ram[addr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= rx_data;
    end
  end

  always_comb begin
    w_rd_data = 8'h00;
    if (w_ram_hit) begin
      w_rd_data = r_ram[addr];
    end else begin
      case (addr)
        8'hF0:   w_rd_data = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
        8'hF1:   w_rd_data = {6'b0, w_full, !w_empty};
        8'hF2:   w_rd_data = r_tx_data;
        8'hF3:   w_rd_data = {6'b0, r_overrun, r_tx_valid};
        8'hF4:   w_rd_data = r_gpio;
        8'hF5:   w_rd_data = w_timer_val;
        default: w_rd_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out <= 8'h00;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_gpio     <= 8'h00;
    end else begin
      if (w_rd) begin
        r_data_out <= w_rd_data;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_tx_wr && w_tx_accept) begin
        r_tx_data  <= data_in;
        r_tx_valid <= 1'b1;
      end else if (w_tx_xfer) begin
        r_tx_valid <= 1'b0;
      end
      if (w_tx_wr && !w_tx_accept) begin
        r_overrun <= 1'b1;
      end else if (w_rd && (addr == 8'hF3)) begin
        r_overrun <= 1'b0;
      end
      if (wren && (addr == 8'hF4)) begin
        r_gpio <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: data_out scoreboard queue plus direct checks of host-side signals.
module tb_mem_io_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] addr = 8'h00, data_in = 8'h00, rx_data = 8'h00;
  logic       rden = 1'b0, wren = 1'b0, rx_valid = 1'b0, tx_ready = 1'b0;
  logic [7:0] data_out, tx_data, gpio_out;
  logic       rx_ready, tx_valid;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_model[$];
  logic [7:0] last_exp = 8'h00;
  logic [7:0] e;
  logic       was_full;

  mem_io_responder #(.RAM_DEPTH(224), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .rden(rden), .wren(wren),
    .data_out(data_out), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One CPU bus cycle; data_out expectation goes through the scoreboard queue.
  task automatic cpu_op(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd);
    rden = rd; wren = wr; addr = a; data_in = d;
    if (rd && !wr) last_exp = exp_rd;
    exp_q.push_back(last_exp);
    @(posedge clk); #1;
    rden = 1'b0; wren = 1'b0; rx_valid = 1'b0;
    $display("op rd=%0d wr=%0d addr=%02h din=%02h dout=%02h", rd, wr, a, d, data_out);
    chk("dout", data_out, exp_q.pop_front());
  endtask

  task automatic wr_op(input logic [7:0] a, input logic [7:0] d);
    cpu_op(1'b0, 1'b1, a, d, 8'h00);
  endtask

  task automatic rd_op(input logic [7:0] a, input logic [7:0] x);
    cpu_op(1'b1, 1'b0, a, 8'h00, x);
  endtask

  task automatic idle();
    cpu_op(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic host_push(input logic [7:0] d);
    rx_valid = 1'b1; rx_data = d;
    if (rx_model.size() < 4) rx_model.push_back(d);
    idle();
  endtask

  task automatic rx_pop_read();
    e = (rx_model.size() > 0) ? rx_model.pop_front() : 8'h00;
    rd_op(8'hF0, e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_exp = 8'h00;
    rx_model.delete();
    $display("reset dout=%02h tx_valid=%0d rx_ready=%0d gpio=%02h", data_out, tx_valid, rx_ready, gpio_out);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_txv", tx_valid, 1'b0);
    chk("rst_txd", tx_data, 8'h00);
    chk("rst_rxrdy", rx_ready, 1'b1);
    chk("rst_gpio", gpio_out, 8'h00);
  endtask

  initial begin
    // Reset and RAM window
    @(posedge clk); #1;
    do_reset();
    wr_op(8'h10, 8'h5A);
    rd_op(8'h10, 8'h5A);
    rd_op(8'hE8, 8'h00);
    wr_op(8'hE8, 8'h99);
    rd_op(8'hE8, 8'h00);
    rd_op(8'h10, 8'h5A);
    cpu_op(1'b1, 1'b1, 8'h11, 8'h77, 8'h00);
    idle();
    rd_op(8'h11, 8'h77);
    rd_op(8'hF9, 8'h00);

    // RX FIFO fill, overflow, drain, underflow
    host_push(8'h11); host_push(8'h22); host_push(8'h33); host_push(8'h44);
    chk("rx_full_rdy", rx_ready, 1'b0);
    rd_op(8'hF1, 8'h03);
    host_push(8'h55);
    chk("rx_full_rdy2", rx_ready, 1'b0);
    for (int i = 0; i < 5; i++) rx_pop_read();
    rd_op(8'hF1, 8'h00);
    chk("rx_empty_rdy", rx_ready, 1'b1);

    // TX holding register and overrun
    tx_ready = 1'b0;
    wr_op(8'hF2, 8'h41);
    chk("tx_v1", tx_valid, 1'b1);
    chk("tx_d1", tx_data, 8'h41);
    wr_op(8'hF2, 8'h42);
    chk("tx_d_held", tx_data, 8'h41);
    rd_op(8'hF2, 8'h41);
    rd_op(8'hF3, 8'h03);
    rd_op(8'hF3, 8'h01);
    tx_ready = 1'b1;
    idle();
    tx_ready = 1'b0;
    chk("tx_v_drop", tx_valid, 1'b0);
    wr_op(8'hF2, 8'h61);
    tx_ready = 1'b1;
    wr_op(8'hF2, 8'h62);
    chk("tx_xfer_wr_v", tx_valid, 1'b1);
    chk("tx_xfer_wr_d", tx_data, 8'h62);
    tx_ready = 1'b0;
    rd_op(8'hF3, 8'h01);
    tx_ready = 1'b1;
    idle();
    tx_ready = 1'b0;
    chk("tx_v_drop2", tx_valid, 1'b0);

    // Full FIFO with simultaneous push and pop: push refused
    host_push(8'hA1); host_push(8'hA2); host_push(8'hA3); host_push(8'hA4);
    was_full = (rx_model.size() == 4);
    e = rx_model.pop_front();
    if (!was_full) rx_model.push_back(8'hB0);
    rx_valid = 1'b1; rx_data = 8'hB0;
    rd_op(8'hF0, e);
    rd_op(8'hF1, 8'h01);
    chk("rx_rdy_after", rx_ready, 1'b1);
    for (int i = 0; i < 3; i++) rx_pop_read();
    rd_op(8'hF1, 8'h00);
    // Push and pop together on a partly filled FIFO
    host_push(8'hC1);
    e = rx_model.pop_front();
    rx_model.push_back(8'hC2);
    rx_valid = 1'b1; rx_data = 8'hC2;
    rd_op(8'hF0, e);
    rd_op(8'hF1, 8'h01);
    rx_pop_read();
    rx_pop_read();

    // GPIO and timer
    wr_op(8'hF4, 8'h3C);
    chk("gpio", gpio_out, 8'h3C);
    rd_op(8'hF4, 8'h3C);
`ifdef MEMIO_TIMER_EN
    wr_op(8'hF5, 8'hEE);
    idle(); idle(); idle();
    rd_op(8'hF5, 8'h03);
    for (int i = 0; i < 252; i++) idle();
    rd_op(8'hF5, 8'h00);
    rd_op(8'hF5, 8'h01);
`else
    wr_op(8'hF5, 8'hEE);
    idle(); idle(); idle();
    rd_op(8'hF5, 8'h00);
    rd_op(8'hF4, 8'h3C);
    rd_op(8'hF5, 8'h00);
`endif

    // Reset mid-operation
    host_push(8'hD1); host_push(8'hD2);
    wr_op(8'hF2, 8'h77);
    chk("pre_rst_txv", tx_valid, 1'b1);
    rd_op(8'hF4, 8'h3C);
    do_reset();
    rd_op(8'hF1, 8'h00);
    rd_op(8'h10, 8'h5A);
    rd_op(8'hF4, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
